// File: rtl/pdm_mic_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_mic_rx_if
//  Purpose  : iomem-style bus bundle for the PDM microphone receiver
//             (select / one-cycle ready handshake, byte strobes, 24-bit addr).
//  Revision : 1.0  initial release
// ============================================================================
interface pdm_mic_rx_if;
    logic        sel;
    logic        ready;
    logic [3:0]  wstrb;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, wstrb, addr, wdata, input ready, rdata);
    modport slave  (input sel, wstrb, addr, wdata, output ready, rdata);
endinterface
`default_nettype wire

// File: rtl/pdm_mic_rx.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_mic_rx
//  Purpose  : PDM microphone receiver. Generates pdm_clk, samples pdm_dat on
//             the rising edge, decimates with a 3rd-order CIC into 16-bit PCM
//             and queues samples in a FIFO drained over the iomem bus.
//  Options  : PDM_MIC_IRQ_EN adds the registered irq output and STATUS bit19.
//  Revision : 1.0  initial release
// ============================================================================
module pdm_mic_rx #(
    parameter int CLKDIV     = 6,
    parameter int LOG2_DECIM = 6,
    parameter int FIFO_DEPTH = 64
) (
    input  wire logic   clk2,
    input  wire logic   resetn,
    pdm_mic_rx_if.slave bus,
    output logic        pdm_clk,
`ifdef PDM_MIC_IRQ_EN
    input  wire logic   pdm_dat,
    output logic        irq
`else
    input  wire logic   pdm_dat
`endif
);
    localparam int c_W  = 3 * LOG2_DECIM + 2;
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0]    c_DIV_LAST = 8'(CLKDIV - 1);
    localparam logic [c_AW:0] c_LVL_FULL = {1'b1, {c_AW{1'b0}}};
    localparam logic [c_AW:0] c_LVL_HALF = {2'b01, {(c_AW - 1){1'b0}}};

    // ---------------- control / status state ----------------
    logic              r_enable;
    logic              r_ovf;
    logic              r_ready;
    logic [31:0]       r_rdata;

    // ---------------- bus decode ----------------
    logic       w_start, w_wr, w_pop, w_flush, w_ovf_clr, w_ovf_set;
    logic [1:0] w_reg;
    logic       w_unused;

    assign w_start   = bus.sel && !r_ready;
    assign w_reg     = bus.addr[3:2];
    assign w_wr      = |bus.wstrb;
    assign w_flush   = w_start && w_wr && (w_reg == 2'd0) && bus.wstrb[0] && bus.wdata[1];
    assign w_ovf_clr = w_start && w_wr && (w_reg == 2'd1) && bus.wstrb[2] && bus.wdata[18];
    assign w_unused  = &{1'b0, bus.addr[23:4], bus.addr[1:0], bus.wdata[31:19], bus.wdata[17:2]};

    // ---------------- bit-clock divider ----------------
    logic [7:0] r_div;
    logic       r_pdm_clk;
    logic       w_tick;

    // A capture tick is the cycle in which pdm_clk is about to go 0 -> 1.
    assign w_tick  = r_enable && (r_div == c_DIV_LAST) && !r_pdm_clk;
    assign pdm_clk = r_pdm_clk;

    // Divider: toggle pdm_clk every CLKDIV cycles, held idle while disabled.
    always_ff @(posedge clk2) begin
        if (!resetn || !r_enable) begin
            r_div     <= '0;
            r_pdm_clk <= 1'b0;
        end else if (r_div == c_DIV_LAST) begin
            r_div     <= '0;
            r_pdm_clk <= ~r_pdm_clk;
        end else begin
            r_div     <= r_div + 8'd1;
        end
    end

    // Two-flop synchronizer for the asynchronous microphone data.
    logic [1:0] r_sync;
    always_ff @(posedge clk2) begin
        if (!resetn) r_sync <= 2'b00;
        else         r_sync <= {r_sync[0], pdm_dat};
    end

    // ---------------- CIC decimator ----------------
    logic [c_W-1:0]        r_i1, r_i2, r_i3, r_d1, r_d2, r_d3;
    logic [c_W-1:0]        w_x, w_c1, w_c2, w_c3;
    logic [LOG2_DECIM-1:0] r_bitcnt;
    logic                  r_dec;
    logic [1:0]            r_settle;
    logic                  w_push_req, w_push;
    logic [15:0]           w_sample;

    assign w_x        = r_sync[1] ? {{(c_W - 1){1'b0}}, 1'b1} : {c_W{1'b1}};
    assign w_c1       = r_i3 - r_d1;
    assign w_c2       = w_c1 - r_d2;
    assign w_c3       = w_c2 - r_d3;
    assign w_sample   = w_c3[c_W-1 -: 16];
    // The first three comb outputs still carry the start-up transient.
    assign w_push_req = r_dec && (r_settle == 2'd3);

    // Integrators at bit rate, combs one cycle after every R-th bit.
    always_ff @(posedge clk2) begin
        if (!resetn || !r_enable) begin
            r_i1 <= '0; r_i2 <= '0; r_i3 <= '0;
            r_d1 <= '0; r_d2 <= '0; r_d3 <= '0;
            r_bitcnt <= '0;
            r_dec    <= 1'b0;
            r_settle <= 2'd0;
        end else begin
            r_dec <= 1'b0;
            if (w_tick) begin
                r_i1     <= r_i1 + w_x;
                r_i2     <= r_i2 + r_i1;
                r_i3     <= r_i3 + r_i2;
                r_bitcnt <= r_bitcnt + 1'b1;
                r_dec    <= (r_bitcnt == '1);
            end
            if (r_dec) begin
                r_d1 <= r_i3;
                r_d2 <= w_c1;
                r_d3 <= w_c2;
                if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
            end
        end
    end

    // ---------------- sample FIFO ----------------
    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [c_AW:0] r_wptr, r_rptr, w_level;
    logic          w_empty, w_full;
    logic [15:0]   w_head;

    assign w_level   = r_wptr - r_rptr;
    assign w_empty   = (w_level == '0);
    assign w_full    = (w_level == c_LVL_FULL);
    assign w_head    = r_mem[r_rptr[c_AW-1:0]];
    assign w_pop     = w_start && !w_wr && (w_reg == 2'd2) && !w_empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_ovf_set = w_push_req && w_full && !w_pop && !w_flush;

    // Sample storage; written whenever a push is accepted.
    always_ff @(posedge clk2) begin
        if (w_push) r_mem[r_wptr[c_AW-1:0]] <= w_sample;
    end

    // FIFO pointers; flush overrides any coincident push.
    always_ff @(posedge clk2) begin
        if (!resetn || w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // ---------------- registers and bus response ----------------
    logic w_irq_bit;

    // CTRL.ENABLE and the sticky overflow flag (set beats clear).
    always_ff @(posedge clk2) begin
        if (!resetn) begin
            r_enable <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_start && w_wr && (w_reg == 2'd0) && bus.wstrb[0]) r_enable <= bus.wdata[0];
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
        end
    end

    logic [31:0] w_rd_val;
    // Read data mux, sampled into rdata on the transaction start cycle.
    always_comb begin
        w_rd_val = '0;
        case (w_reg)
            2'd0:    w_rd_val = {31'b0, r_enable};
            2'd1:    w_rd_val = {12'b0, w_irq_bit, r_ovf, w_full, w_empty, 6'b0, 10'(w_level)};
            2'd2:    w_rd_val = w_empty ? 32'h0 : {{16{w_head[15]}}, w_head};
            default: w_rd_val = '0;
        endcase
    end

    // One-cycle ready pulse with registered read data, zero when idle.
    always_ff @(posedge clk2) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_start;
            r_rdata <= w_start ? w_rd_val : 32'h0;
        end
    end

    assign bus.ready = r_ready;
    assign bus.rdata = r_rdata;

`ifdef PDM_MIC_IRQ_EN
    logic r_irq;
    // Service request: half-full or overflow while the receiver is enabled.
    always_ff @(posedge clk2) begin
        if (!resetn) r_irq <= 1'b0;
        else         r_irq <= r_enable && ((w_level >= c_LVL_HALF) || r_ovf);
    end
    assign irq       = r_irq;
    assign w_irq_bit = r_irq;
`else
    assign w_irq_bit = 1'b0;
`endif

endmodule
`default_nettype wire
